// File: rtl/button_test_led.sv
// Debounced push-button RGB colour selector: OFF -> GREEN -> RED -> BLUE -> OFF per accepted press.
// Optional BUTTON_LONG_PRESS_EN: holding the button for LONG_PRESS_CYCLES forces the LED back to OFF.
module button_test_led #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic pin_clk_12mhz,
    input  logic pin_rst_n,
    input  logic pin_user_sw,
    output logic green,
    output logic red,
    output logic blue
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GREEN = 2'd1,
        ST_RED   = 2'd2,
        ST_BLUE  = 2'd3
    } state_t;

    logic            sw_meta_r;
    logic            sw_sync_r;
    logic            db_r;
    logic            db_d_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            press_r;
    logic            long_fire_s;
    state_t          state_r;
    state_t          adv_s;
    state_t          state_next_s;
    logic [2:0]      led_r;

    // LED pattern {green, red, blue} for a colour state
    function automatic logic [2:0] led_decode(input state_t s);
        logic [2:0] leds;
        case (s)
            ST_OFF:   leds = 3'b000;
            ST_GREEN: leds = 3'b100;
            ST_RED:   leds = 3'b010;
            ST_BLUE:  leds = 3'b001;
            default:  leds = 3'b000;
        endcase
        return leds;
    endfunction

    // Two-stage synchroniser; idles released (high)
    always_ff @(posedge pin_clk_12mhz or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            sw_meta_r <= 1'b1;
            sw_sync_r <= 1'b1;
        end else begin
            sw_meta_r <= pin_user_sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Debouncer: level follows sw_sync only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge pin_clk_12mhz or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            db_r     <= 1'b1;
            db_cnt_r <= {DB_W{1'b0}};
        end else if (sw_sync_r == db_r) begin
            db_cnt_r <= {DB_W{1'b0}};
        end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_r     <= sw_sync_r;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1);
        end
    end

    // Press pulse on debounced falling edge only
    always_ff @(posedge pin_clk_12mhz or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            db_d_r  <= 1'b1;
            press_r <= 1'b0;
        end else begin
            db_d_r  <= db_r;
            press_r <= db_d_r & ~db_r;
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    logic [HOLD_W-1:0] hold_cnt_r;

    // Saturating hold counter, cleared whenever the button is debounced-released
    always_ff @(posedge pin_clk_12mhz or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (db_r) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (hold_cnt_r != HOLD_W'(LONG_PRESS_CYCLES)) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    // Fires on the single cycle the counter reaches its limit, so only once per press
    assign long_fire_s = ~db_r & (hold_cnt_r == HOLD_W'(LONG_PRESS_CYCLES - 1));
`else
    assign long_fire_s = 1'b0;
`endif

    // Colour FSM next-state logic
    always_comb begin
        adv_s        = ST_OFF;
        state_next_s = state_r;
        case (state_r)
            ST_OFF:   adv_s = ST_GREEN;
            ST_GREEN: adv_s = ST_RED;
            ST_RED:   adv_s = ST_BLUE;
            ST_BLUE:  adv_s = ST_OFF;
            default:  adv_s = ST_OFF;
        endcase
        if (long_fire_s) begin
            state_next_s = ST_OFF;
        end else if (press_r) begin
            state_next_s = adv_s;
        end else begin
            state_next_s = state_r;
        end
    end

    // State and LED registers; LEDs load the decode of the next state so they always mirror state_r
    always_ff @(posedge pin_clk_12mhz or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state_r <= ST_OFF;
            led_r   <= 3'b000;
        end else begin
            state_r <= state_next_s;
            led_r   <= led_decode(state_next_s);
        end
    end

    assign green = led_r[2];
    assign red   = led_r[1];
    assign blue  = led_r[0];

endmodule

// File: tb/tb_button_test_led.sv
// Self-checking bench for button_test_led: directed steps plus random switch traffic
// compared every cycle against a run-length/event-schedule model of the selector.
module tb_button_test_led;

    localparam int D = 4;
    localparam int L = 50;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sw    = 1'b1;
    logic green, red, blue;

    int checks = 0;
    int errors = 0;

    button_test_led #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .pin_clk_12mhz(clk),
        .pin_rst_n    (rst_n),
        .pin_user_sw  (sw),
        .green        (green),
        .red          (red),
        .blue         (blue)
    );

    always #5 clk = ~clk;

    // Reference model: sample delay queue, debounce run length, scheduled colour advances
    int edge_no    = 0;
    bit m_q[$];
    bit m_db;
    int m_run;
    int m_colour;
    int m_adv[$];
    int m_fall;
    bit m_in_reset;

    function automatic void model_reset();
        m_q        = {1'b1, 1'b1};
        m_db       = 1'b1;
        m_run      = 0;
        m_colour   = 0;
        m_adv      = {};
        m_fall     = -1000000;
        m_in_reset = 1'b1;
    endfunction

    function automatic void model_edge(input bit v);
        bit seen;
        bit db_before;
        if (!m_in_reset) begin
            edge_no   = edge_no + 1;
            db_before = m_db;
            m_q.push_back(v);
            seen = m_q.pop_front();
            if (seen != m_db) begin
                m_run = m_run + 1;
                if (m_run == D) begin
                    m_db  = seen;
                    m_run = 0;
                    if (!seen) begin
                        m_fall = edge_no;
                        m_adv.push_back(edge_no + 2);
                    end
                end
            end else begin
                m_run = 0;
            end
            if (m_adv.size() > 0 && m_adv[0] == edge_no) begin
                void'(m_adv.pop_front());
                m_colour = (m_colour + 1) % 4;
            end
            if (LP_EN && !db_before && (edge_no - m_fall) == L) m_colour = 0;
        end
    endfunction

    function automatic logic [2:0] colour_leds(input int c);
        logic [2:0] r;
        r = {(c == 1), (c == 2), (c == 3)};
        return r;
    endfunction

    task automatic check_leds(input string tag);
        logic [2:0] exp;
        exp = colour_leds(m_colour);
        checks = checks + 1;
        assert ({green, red, blue} === exp) else begin
            errors = errors + 1;
            $error("FAIL %s leds got=%b exp=%b t=%0t", tag, {green, red, blue}, exp, $time);
        end
        checks = checks + 1;
        assert ($countones({green, red, blue}) <= 1) else begin
            errors = errors + 1;
            $error("FAIL %s onehot got=%b exp=at_most_one t=%0t", tag, {green, red, blue}, $time);
        end
    endtask

    task automatic expect_colour(input int c, input string tag);
        logic [2:0] exp;
        exp = colour_leds(c);
        checks = checks + 1;
        assert ({green, red, blue} === exp) else begin
            errors = errors + 1;
            $error("FAIL %s colour got=%b exp=%b t=%0t", tag, {green, red, blue}, exp, $time);
        end
    endtask

    task automatic step(input bit v, input string tag);
        sw = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_leds(tag);
    endtask

    task automatic run(input bit v, input int n, input string tag);
        for (int i = 0; i < n; i++) step(v, tag);
    endtask

    task automatic reset_assert();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks = checks + 1;
        assert ({green, red, blue} === 3'b000) else begin
            errors = errors + 1;
            $error("FAIL rst_async got=%b exp=000 t=%0t", {green, red, blue}, $time);
        end
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n      = 1'b1;
        m_in_reset = 1'b0;
    endtask

    initial begin
        bit bounce [6];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();

        // Reset held 3 cycles, then idle
        run(1'b1, 3, "reset_hold");
        reset_release();
        run(1'b1, 20, "idle");
        expect_colour(0, "idle_off");

        // Single-cycle glitch is rejected
        step(1'b0, "glitch");
        run(1'b1, 20, "glitch_after");
        expect_colour(0, "glitch_off");

        // Four clean presses cycle the colours
        for (int p = 0; p < 4; p++) begin
            run(1'b0, 20, "press_low");
            expect_colour((p + 1) % 4, "press_colour");
            run(1'b1, 20, "press_high");
        end

        // Bounce train settling low gives one advance
        for (int i = 0; i < 6; i++) step(bounce[i], "bounce");
        run(1'b0, 20, "bounce_hold");
        expect_colour(1, "bounce_green");
        run(1'b1, 20, "bounce_release");

        // Reach RED mid-press, then reset with the switch still held
        run(1'b0, 12, "to_red");
        expect_colour(2, "red_before_rst");
        reset_assert();
        run(1'b0, 3, "rst_held_low");
        reset_release();
        run(1'b0, 20, "post_rst_hold");
        expect_colour(1, "post_rst_green");
        run(1'b1, 20, "post_rst_release");

        // Long hold from OFF
        reset_assert();
        run(1'b1, 3, "rst2");
        reset_release();
        run(1'b1, 10, "idle2");
        run(1'b0, 60, "long_hold");
        expect_colour(LP_EN ? 0 : 1, "long_hold_end");
        run(1'b1, 20, "long_release");

        // Random switch traffic with occasional resets
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_assert();
                run(1'(($urandom_range(0, 1))), $urandom_range(1, 3), "rnd_rst");
                reset_release();
            end else begin
                run(1'(($urandom_range(0, 1))), $urandom_range(1, 12), "rnd");
            end
        end
        run(1'b1, 20, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
